// File: rtl/seven_seg_display_pkg.sv
// Shared constants for the seven-segment display driver.
// Segment patterns are active-low, bit order gfedcba.
package seven_seg_display_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/seven_seg_display_hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern.
// Used once on the digit mux output.
module hex_to_seg
    import seven_seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_display.sv
// Time-multiplexed 4-digit common-anode hex display driver
// with halt blink and optional leading-zero blanking.
module seven_seg_display
    import seven_seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        halt,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [15:0]   disp;
    logic [PW-1:0] pcnt;
    logic [BW-1:0] bcnt;
    logic [1:0]    idx;
    logic          phase;
    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    pattern;
    logic          upper_zero;
    logic          slot_dark;
    logic [3:0]    an_next;

    assign tick   = (pcnt == PW'(REFRESH_DIV - 1));
    assign nibble = disp[{idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Digit k>=1 is a leading zero when it and every higher digit are 0.
    always_comb begin
        upper_zero = 1'b0;
        case (idx)
            2'd1:    upper_zero = (disp[15:4] == 12'h000);
            2'd2:    upper_zero = (disp[15:8] == 8'h00);
            2'd3:    upper_zero = (disp[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    assign slot_dark = phase | (blank_lz & upper_zero);
    assign an_next   = slot_dark ? AN_OFF : ~(4'b0001 << idx);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp <= 16'h0000;
        end else if (load) begin
            disp <= value_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Blink state is held clear whenever the core is running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!halt) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (tick) begin
            an  <= an_next;
            seg <= pattern;
            dp  <= ~((idx == 2'd0) & halt);
        end
    end

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display with REFRESH_DIV=4, BLINK_DIV=2.
// Inputs change on negedges; outputs are sampled on negedges.
module tb_seven_seg_display;

    logic        clk;
    logic        rstn;
    logic [15:0] value_in;
    logic        load;
    logic        halt;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks;
    int n_fails;

    seven_seg_display #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .value_in (value_in),
        .load     (load),
        .halt     (halt),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] a,
                            input logic [6:0] s);
        chk({tag, ".an"}, {4'h0, an}, {4'h0, a});
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, s});
    endtask

    task automatic load_val(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rstn     = 1'b0;
        value_in = 16'h0000;
        load     = 1'b0;
        halt     = 1'b0;
        blank_lz = 1'b0;

        // reset
        step(3);
        chk_slot("rst", 4'hF, 7'h7F);
        chk("rst.dp", {7'h0, dp}, 8'h01);
        rstn = 1'b1;
        step(3);
        chk("rst.edge3.an", {4'h0, an}, 8'h0F);
        step(1);
        chk_slot("rst.edge4", 4'hE, 7'h40);
        chk("rst.edge4.dp", {7'h0, dp}, 8'h01);

        // scan, next slot is idx1
        load_val(16'h1A3F);
        step(3);
        chk_slot("scan.d1", 4'hD, 7'h30);
        step(4);
        chk_slot("scan.d2", 4'hB, 7'h08);
        step(4);
        chk_slot("scan.d3", 4'h7, 7'h79);
        step(4);
        chk_slot("scan.d0", 4'hE, 7'h0E);
        step(4);
        chk_slot("scan.wrap", 4'hD, 7'h30);

        // load/tick collision, next slot idx2
        load_val(16'h0000);
        step(3);
        chk_slot("coll.pre", 4'hB, 7'h40);
        step(3);
        chk_slot("coll.hold", 4'hB, 7'h40);
        value_in = 16'hFFFF;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        chk_slot("coll.same", 4'h7, 7'h40);
        step(4);
        chk_slot("coll.next", 4'hE, 7'h0E);

        // leading-zero blanking, next slot idx1
        blank_lz = 1'b1;
        load_val(16'h0030);
        step(3);
        chk_slot("lz.d1", 4'hD, 7'h30);
        step(4);
        chk("lz.d2.an", {4'h0, an}, 8'h0F);
        step(4);
        chk("lz.d3.an", {4'h0, an}, 8'h0F);
        step(4);
        chk_slot("lz.d0", 4'hE, 7'h40);
        step(4);
        chk_slot("lz.d1b", 4'hD, 7'h30);
        load_val(16'h0000);
        step(3);
        chk("lz0.d2.an", {4'h0, an}, 8'h0F);
        step(4);
        chk("lz0.d3.an", {4'h0, an}, 8'h0F);
        step(4);
        chk_slot("lz0.d0", 4'hE, 7'h40);
        step(4);
        chk("lz0.d1.an", {4'h0, an}, 8'h0F);

        // halt blink, next slot idx2
        blank_lz = 1'b0;
        load_val(16'h1A3F);
        step(3);
        chk_slot("pre.d2", 4'hB, 7'h08);
        step(4);
        chk_slot("pre.d3", 4'h7, 7'h79);
        halt = 1'b1;
        step(4);
        chk_slot("blink.d0", 4'hE, 7'h0E);
        chk("blink.d0.dp", {7'h0, dp}, 8'h00);
        step(4);
        chk("blink.d1.an", {4'h0, an}, 8'h0D);
        chk("blink.d1.dp", {7'h0, dp}, 8'h01);
        step(4);
        chk("blink.d2.an", {4'h0, an}, 8'h0F);
        step(4);
        chk("blink.d3.an", {4'h0, an}, 8'h0F);
        chk("blink.d3.dp", {7'h0, dp}, 8'h01);
        step(4);
        chk("blink.d0b.an", {4'h0, an}, 8'h0E);
        chk("blink.d0b.dp", {7'h0, dp}, 8'h00);
        step(4);
        chk("blink.d1b.an", {4'h0, an}, 8'h0D);
        halt = 1'b0;
        step(4);
        chk_slot("unhalt.d2", 4'hB, 7'h08);
        chk("unhalt.d2.dp", {7'h0, dp}, 8'h01);
        step(4);
        chk_slot("unhalt.d3", 4'h7, 7'h79);

        // async reset while idx2 is pending
        step(4);
        chk_slot("ar.d0", 4'hE, 7'h0E);
        step(4);
        chk_slot("ar.d1", 4'hD, 7'h30);
        step(2);
        #2 rstn = 1'b0;
        #1;
        chk_slot("ar.async", 4'hF, 7'h7F);
        chk("ar.async.dp", {7'h0, dp}, 8'h01);
        @(negedge clk);
        rstn = 1'b1;
        step(3);
        chk("ar.edge3.an", {4'h0, an}, 8'h0F);
        step(1);
        chk_slot("ar.edge4", 4'hE, 7'h40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
